// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller for the shared 16-bit ALU.
// Holds a small register file, accepts instruction words over valid/ready,
// presents registered operands to the external combinational ALU, captures
// its result and flags, and writes the result back.
module alu_sequencer #(
  parameter int DATA_W    = 16,
  parameter int NREGS     = 4,
  parameter int FLAG_W    = 5,
  parameter int CARRY_BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              ld_valid,
  input  logic [1:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_r1,
  output logic [DATA_W-1:0] alu_r2,
  output logic [7:0]        alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [FLAG_W-1:0] flags,
  output logic [DATA_W-1:0] disp_value,
  output logic              done,
  output logic              busy,
  output logic [15:0]       op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_alu_r1;
  logic [DATA_W-1:0] r_alu_r2;
  logic [7:0]        r_alu_opcode;
  logic              r_alu_cin;
  logic [FLAG_W-1:0] r_flags;
  logic [DATA_W-1:0] r_disp;
  logic              r_done;
  logic [15:0]       r_op_count;

  // Instruction register fields
  logic [7:0] w_opcode;
  logic [1:0] w_rd;
  logic [1:0] w_rs1;
  logic [1:0] w_rs2;
  logic       w_use_carry;
  logic       w_no_wb;
  logic       w_ld_we;
  logic       w_accept;
  logic       w_wb_we;

  assign w_opcode    = r_ir[15:8];
  assign w_rd        = r_ir[7:6];
  assign w_rs1       = r_ir[5:4];
  assign w_rs2       = r_ir[3:2];
  assign w_use_carry = r_ir[1];
  assign w_no_wb     = r_ir[0];

  // A load in IDLE takes priority over an offered instruction; ready also
  // drops while reset is held so nothing is accepted across reset release.
  assign instr_ready = (r_state == S_IDLE) && !ld_valid && !rst;
  assign w_ld_we     = (r_state == S_IDLE) && ld_valid;
  assign w_accept    = instr_valid && instr_ready;
  assign w_wb_we     = (r_state == S_WB) && !w_no_wb;

  assign alu_r1     = r_alu_r1;
  assign alu_r2     = r_alu_r2;
  assign alu_opcode = r_alu_opcode;
  assign alu_cin    = r_alu_cin;
  assign flags      = r_flags;
  assign disp_value = r_disp;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE);
  assign op_count   = r_op_count;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: fixed four-step walk once an instruction is taken
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_READ;
      S_READ:  w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_WB;
      S_WB:    w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Register file: direct loads in IDLE, result write-back in WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_ld_we) begin
      r_regs[ld_addr] <= ld_data;
    end else if (w_wb_we) begin
      r_regs[w_rd] <= r_result;
    end
  end

  // Instruction capture, ALU drive, result/flag capture and write-back side effects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir         <= '0;
      r_alu_r1     <= '0;
      r_alu_r2     <= '0;
      r_alu_opcode <= '0;
      r_alu_cin    <= 1'b0;
      r_result     <= '0;
      r_flags      <= '0;
      r_disp       <= '0;
      r_done       <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_ir <= instr;
        end
        S_READ: begin
          r_alu_r1     <= r_regs[w_rs1];
          r_alu_r2     <= r_regs[w_rs2];
          r_alu_opcode <= w_opcode;
          // Carry comes from the previous completed instruction's flags
          r_alu_cin    <= w_use_carry ? r_flags[CARRY_BIT] : 1'b0;
        end
        S_EXEC: begin
          r_result <= alu_out;
          r_flags  <= alu_flags;
        end
        S_WB: begin
          if (!w_no_wb) r_disp <= r_result;
          r_done     <= 1'b1;
          r_op_count <= r_op_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
